// File: rtl/serial_paralelo.sv
// -----------------------------------------------------------------------------
// serial_paralelo
//
// Serial-to-parallel deserializer with comma alignment. The incoming bit
// stream (MSB first, one bit per clk8f) is searched for the COMMA byte at any
// bit phase. Once a COMMA is found, the byte phase is locked. BC_THRESHOLD
// consecutive aligned COMMAs declare the link active. While active, each byte
// boundary produces a recovered byte on paralelo_out. COMMA bytes are treated
// as idle: they clear the valid bit and keep the last data byte.
//
// Parameters:
//   COMMA         idle / alignment byte
//   BC_THRESHOLD  consecutive aligned COMMAs needed to go active (>= 1)
//
// Ports:
//   clk8f         bit clock; all state changes on its rising edge
//   reset_L       asynchronous, active-low reset
//   serial        serial input stream
//   paralelo_out  recovered byte: [8] = valid, [7:0] = data
//   active        high once the link is declared active (sticky until reset)
//   byte_strobe   one-cycle pulse on every byte boundary while active
// -----------------------------------------------------------------------------
module serial_paralelo #(
    parameter logic [7:0] COMMA        = 8'hBC,
    parameter int         BC_THRESHOLD = 4
) (
    input  logic       clk8f,
    input  logic       reset_L,
    input  logic       serial,
    output logic [8:0] paralelo_out,
    output logic       active,
    output logic       byte_strobe
);

    localparam int BC_W = (BC_THRESHOLD < 1) ? 1 : $clog2(BC_THRESHOLD + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(BC_THRESHOLD);
    localparam logic [BC_W-1:0] BC_ONE = BC_W'(1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ALIGNED = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      shift;
    logic [2:0]      bit_cnt, bit_cnt_nxt;
    logic [BC_W-1:0] bc_count, bc_count_nxt;
    logic [8:0]      paralelo_nxt;
    logic            active_nxt;
    logic            strobe_nxt;

    logic [7:0]      candidate;
    logic            is_comma;
    logic            byte_done;

    // The newest bit enters as the LSB, so the candidate byte is always the
    // last eight bits seen, including the one sampled on this edge.
    assign candidate = {shift[6:0], serial};
    assign is_comma  = (candidate == COMMA);
    assign byte_done = (bit_cnt == 3'd7);

    always_ff @(posedge clk8f or negedge reset_L) begin
        if (!reset_L) begin
            state        <= SEARCH;
            shift        <= 8'h00;
            bit_cnt      <= 3'd0;
            bc_count     <= '0;
            paralelo_out <= 9'h000;
            active       <= 1'b0;
            byte_strobe  <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift        <= candidate;
            bit_cnt      <= bit_cnt_nxt;
            bc_count     <= bc_count_nxt;
            paralelo_out <= paralelo_nxt;
            active       <= active_nxt;
            byte_strobe  <= strobe_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        bc_count_nxt = bc_count;
        paralelo_nxt = paralelo_out;
        active_nxt   = active;
        strobe_nxt   = 1'b0;

        case (state)
            SEARCH: begin
                bit_cnt_nxt  = 3'd0;
                bc_count_nxt = '0;
                paralelo_nxt = 9'h000;
                if (is_comma) begin
                    // This edge becomes the byte boundary; bit_cnt restarts so
                    // the next boundary lands exactly eight bits later.
                    bc_count_nxt = BC_ONE;
                    if (BC_MAX <= BC_ONE) begin
                        state_nxt  = ACTIVE;
                        active_nxt = 1'b1;
                    end else begin
                        state_nxt = ALIGNED;
                    end
                end
            end

            ALIGNED: begin
                bit_cnt_nxt  = bit_cnt + 3'd1;
                paralelo_nxt = 9'h000;
                if (byte_done) begin
                    if (is_comma) begin
                        if (bc_count >= BC_MAX - BC_ONE) begin
                            state_nxt    = ACTIVE;
                            active_nxt   = 1'b1;
                            bc_count_nxt = BC_MAX;
                        end else begin
                            bc_count_nxt = bc_count + BC_ONE;
                        end
                    end else begin
                        // Broken run of commas: drop lock and hunt again.
                        state_nxt    = SEARCH;
                        bc_count_nxt = '0;
                    end
                end
            end

            ACTIVE: begin
                bit_cnt_nxt = bit_cnt + 3'd1;
                active_nxt  = 1'b1;
                if (byte_done) begin
                    strobe_nxt = 1'b1;
                    // Idle bytes clear valid but keep the last data byte.
                    if (is_comma) begin
                        paralelo_nxt = {1'b0, paralelo_out[7:0]};
                    end else begin
                        paralelo_nxt = {1'b1, candidate};
                    end
                end
            end

            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo
//
// Directed bench for serial_paralelo. Byte-level vectors {byte, expected
// paralelo_out, expected active, expected byte_strobe} are stored in a table
// and replayed bit by bit, MSB first. Hand-written sequences cover junk-bit
// phase offsets and an asynchronous reset in the middle of a byte.
// -----------------------------------------------------------------------------
module tb_serial_paralelo;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk8f = 1'b0;
    logic       reset_L;
    logic       serial;
    logic [8:0] paralelo_out;
    logic       active;
    logic       byte_strobe;

    int checks = 0;
    int errors = 0;

    logic [8:0] held_out;
    logic       held_active;

    typedef struct packed {
        logic [7:0] byte_in;
        logic [8:0] exp_out;
        logic       exp_active;
        logic       exp_strobe;
    } vec_t;

    vec_t vecs[$];

    serial_paralelo #(
        .COMMA        (COMMA),
        .BC_THRESHOLD (4)
    ) dut (
        .clk8f        (clk8f),
        .reset_L      (reset_L),
        .serial       (serial),
        .paralelo_out (paralelo_out),
        .active       (active),
        .byte_strobe  (byte_strobe)
    );

    always #5 clk8f = ~clk8f;

    // Upstream serializer: a valid word sends its data byte, otherwise idle.
    function automatic logic [7:0] serialize(input logic [8:0] word);
        return word[8] ? word[7:0] : COMMA;
    endfunction

    function automatic void addVec(input logic [7:0] b, input logic [8:0] o,
                                   input logic a, input logic s);
        vec_t v;
        v.byte_in    = b;
        v.exp_out    = o;
        v.exp_active = a;
        v.exp_strobe = s;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [8:0] actual,
                               input logic [8:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 9'h%03h, expected 9'h%03h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one bit, let the DUT sample it, then settle just after the edge.
    task automatic sendBit(input logic b);
        serial = b;
        @(posedge clk8f);
        #1;
    endtask

    // Send one byte; just before its last bit, outputs must still hold the
    // previous values, and after the last bit they must match the vector.
    task automatic applyStimulus(input vec_t v, input string tag);
        for (int i = 7; i >= 0; i--) begin
            sendBit(v.byte_in[i]);
            if (i == 1) begin
                checkOutput({tag, " hold out"}, paralelo_out, held_out);
                checkOutput({tag, " hold strobe"}, {8'b0, byte_strobe}, 9'h000);
                checkOutput({tag, " hold active"}, {8'b0, active}, {8'b0, held_active});
            end
        end
        checkOutput({tag, " out"}, paralelo_out, v.exp_out);
        checkOutput({tag, " active"}, {8'b0, active}, {8'b0, v.exp_active});
        checkOutput({tag, " strobe"}, {8'b0, byte_strobe}, {8'b0, v.exp_strobe});
        held_out    = v.exp_out;
        held_active = v.exp_active;
    endtask

    task automatic runVecs(input int first, input int last, input string label);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i], $sformatf("%s[%0d] byte %02h", label, i, vecs[i].byte_in));
        end
    endtask

    task automatic doReset(input string tag);
        reset_L = 1'b0;
        serial  = 1'b0;
        repeat (2) @(posedge clk8f);
        #1;
        checkOutput({tag, " reset out"}, paralelo_out, 9'h000);
        checkOutput({tag, " reset active"}, {8'b0, active}, 9'h000);
        checkOutput({tag, " reset strobe"}, {8'b0, byte_strobe}, 9'h000);
        reset_L     = 1'b1;
        held_out    = 9'h000;
        held_active = 1'b0;
    endtask

    initial begin
        // 0..6: four aligned commas go active, then data / idle / data.
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b1, 1'b0);
        addVec(8'hA5, 9'h1A5, 1'b1, 1'b1);
        addVec(8'hBC, 9'h0A5, 1'b1, 1'b1);
        addVec(8'h3C, 9'h13C, 1'b1, 1'b1);
        // 7..14: a broken comma run must start the count over.
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'h00, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b1, 1'b0);
        // 15..19: after three junk bits.
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b0, 1'b0);
        addVec(8'hBC, 9'h000, 1'b1, 1'b0);
        addVec(8'h5A, 9'h15A, 1'b1, 1'b1);
        // 20..28: bytes produced by the upstream serializer model.
        addVec(serialize(9'h000), 9'h000, 1'b0, 1'b0);
        addVec(serialize(9'h000), 9'h000, 1'b0, 1'b0);
        addVec(serialize(9'h000), 9'h000, 1'b0, 1'b0);
        addVec(serialize(9'h000), 9'h000, 1'b1, 1'b0);
        addVec(serialize(9'h000), 9'h000, 1'b1, 1'b1);
        addVec(serialize(9'h1FF), 9'h1FF, 1'b1, 1'b1);
        addVec(serialize(9'h100), 9'h100, 1'b1, 1'b1);
        addVec(serialize(9'h181), 9'h181, 1'b1, 1'b1);
        addVec(serialize(9'h000), 9'h081, 1'b1, 1'b1);

        $display("[TB] starting serial_paralelo bench");

        doReset("basic");
        runVecs(0, 6, "basic");

        // Asynchronous reset in the middle of a byte while active.
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        #2;
        reset_L = 1'b0;
        #1;
        checkOutput("async reset out", paralelo_out, 9'h000);
        checkOutput("async reset active", {8'b0, active}, 9'h000);
        checkOutput("async reset strobe", {8'b0, byte_strobe}, 9'h000);
        @(posedge clk8f);
        #1;
        checkOutput("reset held out", paralelo_out, 9'h000);
        checkOutput("reset held active", {8'b0, active}, 9'h000);
        reset_L     = 1'b1;
        held_out    = 9'h000;
        held_active = 1'b0;
        runVecs(0, 4, "after reset");

        doReset("broken run");
        runVecs(7, 14, "broken run");

        doReset("junk");
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("junk active", {8'b0, active}, 9'h000);
        runVecs(15, 19, "junk");

        doReset("serdes");
        runVecs(20, 28, "serdes");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
